fetch_unit: RTL and testbench

- Front end of the pipeline. Generates sequential PCs and issues reads to a synchronous instruction memory.
- Buffers returned instructions with their PCs in a small queue and presents them to decode through a valid/ready handshake as {pc, instr}.
- Supports a redirect/flush from the back end, and halts at the end of the program (all-zero instruction word).

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front end.
package fetch_unit_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 12;
  localparam int unsigned INSTR_WIDTH_DEF = 32;
  localparam int unsigned QUEUE_DEPTH_DEF = 4;
  localparam int unsigned PC_INCREMENT    = 4;

  localparam logic [11:0] RESET_PC_DEF        = 12'h000;
  localparam logic [31:0] END_OF_PROGRAM_WORD = 32'h0000_0000;

  // Fetching until the end-of-program word returns, then parked until redirected.
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries; head is read from
// registered storage (no write-through bypass) and reads as zero when empty.
module fetch_queue #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 44,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && !i_clear && w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally modulo the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-checked reads
// to a 1-cycle synchronous imem, fetch queue toward decode, flush/redirect and
// halt on the all-zero word.
// Optional: define FETCH_TRACE_EN for simulation-only fetch/flush/halt trace.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned          INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned          QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   done
);

  localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned ENTRY_W = PC_WIDTH + INSTR_WIDTH;
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(PC_INCREMENT - 1);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PC_WIDTH-1:0] r_req_pc;
  logic                r_outstanding;
  logic                r_discard;
  logic                w_resp_live;
  logic                w_resp_eop;
  logic                w_push;
  logic                w_pop;
  logic                w_halt_hit;
  logic [CNT_W:0]      w_credit_used;
  logic [CNT_W-1:0]    w_count;
  logic [ENTRY_W-1:0]  w_head;

  // Next state, issue credit check, response steering and done.
  always_comb begin
    w_state_nxt   = r_state;
    imem_req      = 1'b0;
    done          = 1'b0;
    w_push        = 1'b0;
    w_halt_hit    = 1'b0;
    w_resp_live   = r_outstanding && !r_discard && !flush;
    w_resp_eop    = (imem_rdata == INSTR_WIDTH'(END_OF_PROGRAM_WORD));
    w_credit_used = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_outstanding);
    case (r_state)
      ST_FETCH: begin
        imem_req = !flush && !rst && (w_credit_used < (CNT_W+1)'(QUEUE_DEPTH));
        if (w_resp_live) begin
          if (w_resp_eop) begin
            w_halt_hit  = 1'b1;
            w_state_nxt = ST_HALT;
          end else begin
            w_push = 1'b1;
          end
        end
      end
      ST_HALT: begin
        done = (w_count == '0) && !r_outstanding;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
    if (flush) w_state_nxt = ST_FETCH;
  end

  // State, fetch PC and in-flight tracking; a flush cancels the pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FETCH;
      r_fetch_pc    <= RESET_PC & ALIGN_MASK;
      r_req_pc      <= '0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_fetch_pc    <= redirect_pc & ALIGN_MASK;
        r_outstanding <= 1'b0;
        r_discard     <= 1'b0;
      end else begin
        r_outstanding <= imem_req;
        // The read issued alongside the halting response must not enqueue.
        r_discard     <= imem_req && w_halt_hit;
        if (imem_req) begin
          r_fetch_pc <= r_fetch_pc + PC_WIDTH'(PC_INCREMENT);
          r_req_pc   <= r_fetch_pc;
        end
      end
    end
  end

  assign w_pop     = valid_out && ready_in;
  assign valid_out = (w_count != '0);
  assign imem_addr = r_fetch_pc;
  assign {pc_out, instr_out} = w_head;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_push  (w_push),
    .i_data  ({r_req_pc, imem_rdata}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

`ifdef FETCH_TRACE_EN
  // Simulation trace of enqueues, redirects and program end.
  always @(posedge clk) begin
    if (!rst) begin
      if (flush)      $display("FLUSH -> %h", redirect_pc);
      if (w_push)     $display("FETCH pc=%h instr=%h", r_req_pc, imem_rdata);
      if (w_halt_hit) $display("HALT at %h", r_req_pc);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// ready/flush/reset traffic scored against an in-order program-stream model.
module tb_fetch_unit;

  typedef struct packed {
    logic [11:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        valid_out;
  logic        ready_in;
  logic [11:0] pc_out;
  logic [31:0] instr_out;
  logic        flush;
  logic [11:0] redirect_pc;
  logic        done;

  logic [31:0] mem [1024];
  ent_t        exp_q[$];
  logic [11:0] acc_pcs[$];
  bit          exp_term;
  int          total;
  int          bad;
  int          n_req;
  int          since_rst;
  int          first_valid;
  int          drained;

  fetch_unit #(
    .PC_WIDTH    (12),
    .INSTR_WIDTH (32),
    .QUEUE_DEPTH (4),
    .RESET_PC    (12'h000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .pc_out      (pc_out),
    .instr_out   (instr_out),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory: data one cycle after the request, junk otherwise.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr[11:2]];
    else          imem_rdata <= $urandom;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Expected delivery stream: sequential words from start up to the first zero word.
  function automatic void build_exp(input logic [11:0] start);
    logic [11:0] pc;
    ent_t        e;
    pc = start;
    exp_q.delete();
    exp_term = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[pc[11:2]] == 32'h0) begin
        exp_term = 1'b1;
        return;
      end
      e.pc    = pc;
      e.instr = mem[pc[11:2]];
      exp_q.push_back(e);
      pc = pc + 12'd4;
    end
  endfunction

  // One clock cycle: drive inputs after the falling edge, check, then score the edge.
  task automatic cyc(input logic f, input logic [11:0] rpc, input logic rdy, input logic r);
    ent_t e;
    @(negedge clk);
    rst         = r;
    flush       = f;
    redirect_pc = rpc;
    ready_in    = rdy;
    #1;
    if (r) begin
      since_rst   = -1;
      first_valid = -1;
    end else begin
      since_rst++;
    end
    if (!r && valid_out && first_valid < 0) first_valid = since_rst;
    if (imem_req) n_req++;
    if (r || f) check_eq("req_blocked", 64'(imem_req), 64'd0);
    if (imem_req) check_eq("addr_align", 64'(imem_addr[1:0]), 64'd0);
    if (valid_out) begin
      check_eq("head_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check_eq("head_pc", 64'(pc_out), 64'(e.pc));
        check_eq("head_instr", 64'(instr_out), 64'(e.instr));
      end
    end else begin
      check_eq("empty_head", 64'({pc_out, instr_out}), 64'd0);
    end
    if (done) check_eq("done_drained", 64'(exp_q.size()), 64'd0);
    if (valid_out && rdy && !f && !r && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      acc_pcs.push_back(e.pc);
    end
    if (r) begin
      build_exp(12'h000);
      acc_pcs.delete();
    end else if (f) begin
      build_exp(rpc);
    end
    if (!r && !f && exp_term && exp_q.size() == 0) drained++;
    else drained = 0;
    if (drained >= 8) check_eq("done_after_drain", 64'(done), 64'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic load_seq_prog();
    clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i + 1);
  endtask

  task automatic load_t1_prog();
    clear_mem();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h0000_0000;
  endtask

  initial begin
    int found;
    rst = 1'b1; flush = 1'b0; redirect_pc = '0; ready_in = 1'b0;
    total = 0; bad = 0; n_req = 0; since_rst = -1; first_valid = -1; drained = 0;
    exp_term = 1'b0;
    clear_mem();

    // Straight-line program with decode always ready.
    load_t1_prog();
    cyc(0, 12'h0, 1, 1);
    cyc(0, 12'h0, 1, 1);
    check_eq("rst_valid", 64'(valid_out), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_req", 64'(imem_req), 64'd0);
    cyc(0, 12'h0, 1, 0);
    check_eq("t1_first_req", 64'(imem_req), 64'd1);
    check_eq("t1_first_addr", 64'(imem_addr), 64'h000);
    repeat (12) cyc(0, 12'h0, 1, 0);
    check_eq("t1_latency", 64'(first_valid), 64'd2);
    check_eq("t1_accepted", 64'(acc_pcs.size()), 64'd3);
    check_eq("t1_done", 64'(done), 64'd1);

    // Backpressure: queue fills, issue stops on credit, order preserved after release.
    cyc(0, 12'h0, 0, 1);
    load_seq_prog();
    cyc(0, 12'h0, 0, 1);
    n_req = 0;
    repeat (10) cyc(0, 12'h0, 0, 0);
    check_eq("t2_reqs", 64'(n_req), 64'd4);
    check_eq("t2_valid", 64'(valid_out), 64'd1);
    check_eq("t2_head_pc", 64'(pc_out), 64'h000);
    check_eq("t2_req_stalled", 64'(imem_req), 64'd0);
    repeat (30) cyc(0, 12'h0, 1, 0);
    check_eq("t2_progress", 64'(acc_pcs.size() >= 14), 64'd1);

    // Flush in the cycle after a read to 0x010.
    cyc(0, 12'h0, 1, 1);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc(0, 12'h0, 1, 0);
      if (imem_req && imem_addr == 12'h010) found = 1;
    end
    check_eq("t3_found_req", 64'(found), 64'd1);
    cyc(1, 12'h040, 1, 0);
    cyc(0, 12'h0, 1, 0);
    check_eq("t3_queue_empty", 64'(valid_out), 64'd0);
    check_eq("t3_req", 64'(imem_req), 64'd1);
    check_eq("t3_addr", 64'(imem_addr), 64'h040);
    repeat (6) cyc(0, 12'h0, 1, 0);

    // Halt, then redirect to 0x100.
    cyc(0, 12'h0, 1, 1);
    load_t1_prog();
    mem[64] = 32'h1111_1113;
    mem[65] = 32'h2222_2223;
    cyc(0, 12'h0, 1, 1);
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      cyc(0, 12'h0, 1, 0);
      if (done) found = 1;
    end
    check_eq("t4_done", 64'(found), 64'd1);
    cyc(0, 12'h0, 1, 0);
    check_eq("t4_done_hold", 64'(done), 64'd1);
    check_eq("t4_halt_noreq", 64'(imem_req), 64'd0);
    cyc(1, 12'h100, 1, 0);
    acc_pcs.delete();
    cyc(0, 12'h0, 1, 0);
    check_eq("t4_done_cleared", 64'(done), 64'd0);
    check_eq("t4_req", 64'(imem_req), 64'd1);
    check_eq("t4_addr", 64'(imem_addr), 64'h100);
    repeat (10) cyc(0, 12'h0, 1, 0);
    check_eq("t4_accepted", 64'(acc_pcs.size()), 64'd2);
    check_eq("t4_done_again", 64'(done), 64'd1);

    // PC wrap from 0xFFC to 0x000.
    mem[1023] = 32'hCAFE_0013;
    mem[0]    = 32'hBEEF_0093;
    mem[1]    = 32'h0;
    cyc(1, 12'hFFC, 1, 0);
    acc_pcs.delete();
    cyc(0, 12'h0, 1, 0);
    check_eq("t5_addr", 64'(imem_addr), 64'hFFC);
    repeat (10) cyc(0, 12'h0, 1, 0);
    check_eq("t5_accepted", 64'(acc_pcs.size()), 64'd2);
    if (acc_pcs.size() >= 2) begin
      check_eq("t5_pc0", 64'(acc_pcs[0]), 64'hFFC);
      check_eq("t5_pc1", 64'(acc_pcs[1]), 64'h000);
    end

    // Reset with three queued entries and a read in flight.
    cyc(0, 12'h0, 0, 1);
    load_seq_prog();
    cyc(0, 12'h0, 0, 1);
    repeat (4) cyc(0, 12'h0, 0, 0);
    cyc(0, 12'h0, 0, 1);
    check_eq("t6_pre_valid", 64'(valid_out), 64'd1);
    cyc(0, 12'h0, 0, 1);
    check_eq("t6_valid", 64'(valid_out), 64'd0);
    check_eq("t6_req", 64'(imem_req), 64'd0);
    check_eq("t6_done", 64'(done), 64'd0);
    cyc(0, 12'h0, 1, 0);
    check_eq("t6_restart_req", 64'(imem_req), 64'd1);
    check_eq("t6_restart_addr", 64'(imem_addr), 64'h000);
    repeat (8) cyc(0, 12'h0, 1, 0);

    // Randomized program, backpressure, redirects and resets.
    cyc(0, 12'h0, 1, 1);
    for (int i = 0; i < 1024; i++) begin
      mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
    end
    cyc(0, 12'h0, 1, 1);
    for (int k = 0; k < 3000; k++) begin
      logic        f;
      logic        r;
      logic        rd;
      logic [11:0] rp;
      r  = ($urandom_range(0, 299) == 0);
      f  = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 9) < 7);
      rp = 12'($urandom) & 12'hFFC;
      cyc(f, rp, rd, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
